// File: rtl/hazard_scheduler_if.sv
// Pipeline hazard bus between the datapath and hazard_scheduler.
// The master drives pipeline register addresses and the memory handshake; the slave returns stall, flush and bypass controls.
interface hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1D, rs2D;
  logic [4:0]       rs1E, rs2E, rdE;
  logic [1:0]       result_srcE;
  logic             pc_srcE;
  logic [4:0]       rdM, rdW;
  logic             reg_writeM, reg_writeW;
  logic             mem_req, mem_ready;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, result_srcE, pc_srcE,
           rdM, rdW, reg_writeM, reg_writeW, mem_req, mem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, stall_cycles, mem_timeout
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, result_srcE, pc_srcE,
           rdM, rdW, reg_writeM, reg_writeW, mem_req, mem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, stall_cycles, mem_timeout
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Five-stage pipeline hazard unit: bypass select, load-use/branch/memory-wait stall and flush, stall-cycle counter.
// Define HAZ_MEM_TIMEOUT_EN to add a MEM_WAIT watchdog that raises a sticky mem_timeout after MEM_TIMEOUT cycles.
module hazard_scheduler #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               reset,
  hazard_scheduler_if.slave hz
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             lw_stall, mem_stall, timeout_hit;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.reg_writeM, hz.rdW, hz.reg_writeW);
  assign hz.ForwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.reg_writeM, hz.rdW, hz.reg_writeW);

  assign lw_stall = (hz.result_srcE == 2'b01) && (hz.rdE != 5'd0) &&
                    ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

`ifdef HAZ_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  // wait_cnt_q counts completed MEM_WAIT cycles, so the last allowed one sees MEM_TIMEOUT-1
  assign timeout_hit    = (state_q == MEM_WAIT) && !hz.mem_ready &&
                          (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign hz.mem_timeout = mem_timeout_q;
`else
  assign timeout_hit    = 1'b0;
  assign hz.mem_timeout = 1'b0;
`endif

  // A timeout releases the pipeline in the same cycle it is detected
  assign mem_stall = (((state_q == MEM_WAIT) && !hz.mem_ready) ||
                      ((state_q == RUN) && hz.mem_req && !hz.mem_ready)) && !timeout_hit;

  always_comb begin
    state_d        = state_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      RUN:      if (hz.mem_req && !hz.mem_ready)   state_d = MEM_WAIT;
      MEM_WAIT: if (hz.mem_ready || timeout_hit)   state_d = RUN;
      default:                                     state_d = RUN;
    endcase
    if (mem_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
`ifdef HAZ_MEM_TIMEOUT_EN
    mem_timeout_d = mem_timeout_q | timeout_hit;
    wait_cnt_d    = (state_q == MEM_WAIT) ? wait_cnt_q + WAIT_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
`ifdef HAZ_MEM_TIMEOUT_EN
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
`ifdef HAZ_MEM_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
`endif
    end
  end

  assign hz.stall_cycles = stall_cycles_q;

  // Reset holds the pipeline flushed; otherwise memory wait beats redirect, which beats load-use
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    if (reset) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (mem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
    end else if (hz.pc_srcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (lw_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed-vector bench for hazard_scheduler; the timeout scenario is compiled when HAZ_MEM_TIMEOUT_EN is defined.
module tb_hazard_scheduler;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   check_count;
  int   fail_count;

  hazard_scheduler_if #(.CNT_W(CNT_W)) hz ();

  hazard_scheduler #(.MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advances one clock, then drives the memory handshake and redirect for the new cycle
  task automatic applyStimulus(input logic req, input logic ready, input logic pc_src);
    @(posedge clk);
    #1;
    hz.mem_req   = req;
    hz.mem_ready = ready;
    hz.pc_srcE   = pc_src;
  endtask

  function automatic logic [31:0] stall_vec();
    return {28'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM};
  endfunction

  function automatic logic [31:0] flush_vec();
    return {30'd0, hz.FlushD, hz.FlushE};
  endfunction

  initial begin
    check_count    = 0;
    fail_count     = 0;
    reset          = 1'b1;
    hz.rs1D        = 5'd0;
    hz.rs2D        = 5'd0;
    hz.rs1E        = 5'd0;
    hz.rs2E        = 5'd0;
    hz.rdE         = 5'd0;
    hz.result_srcE = 2'b00;
    hz.pc_srcE     = 1'b0;
    hz.rdM         = 5'd0;
    hz.rdW         = 5'd0;
    hz.reg_writeM  = 1'b0;
    hz.reg_writeW  = 1'b0;
    hz.mem_req     = 1'b0;
    hz.mem_ready   = 1'b0;

    #3;
    checkOutput("reset_stalls", stall_vec(), 32'h0);
    checkOutput("reset_flush", flush_vec(), 32'h3);
    checkOutput("reset_cnt", 32'(hz.stall_cycles), 32'h0);
    checkOutput("reset_timeout", 32'(hz.mem_timeout), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    checkOutput("idle_stalls", stall_vec(), 32'h0);
    checkOutput("idle_flush", flush_vec(), 32'h0);

    hz.rs1E = 5'd5; hz.rdM = 5'd5; hz.reg_writeM = 1'b1; hz.rdW = 5'd5; hz.reg_writeW = 1'b1;
    #1 checkOutput("fwdA_mem", 32'(hz.ForwardAE), 32'h2);
    hz.reg_writeM = 1'b0;
    #1 checkOutput("fwdA_wb", 32'(hz.ForwardAE), 32'h1);
    hz.rdW = 5'd0;
    #1 checkOutput("fwdA_none", 32'(hz.ForwardAE), 32'h0);
    hz.rs2E = 5'd6; hz.rdM = 5'd6; hz.reg_writeM = 1'b0; hz.rdW = 5'd6; hz.reg_writeW = 1'b1;
    #1 checkOutput("fwdB_wb", 32'(hz.ForwardBE), 32'h1);
    hz.reg_writeM = 1'b1;
    #1 checkOutput("fwdB_mem", 32'(hz.ForwardBE), 32'h2);
    hz.rs2E = 5'd0; hz.rdM = 5'd0; hz.rdW = 5'd0;
    #1 checkOutput("fwdB_x0", 32'(hz.ForwardBE), 32'h0);
    hz.reg_writeM = 1'b0; hz.reg_writeW = 1'b0; hz.rs1E = 5'd0;

    applyStimulus(1'b0, 1'b0, 1'b0);
    hz.result_srcE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
    #2;
    checkOutput("lw_stalls", stall_vec(), 32'hC);
    checkOutput("lw_flush", flush_vec(), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    hz.result_srcE = 2'b00;
    #2;
    checkOutput("lw_after_stalls", stall_vec(), 32'h0);
    checkOutput("lw_after_flush", flush_vec(), 32'h0);
    hz.result_srcE = 2'b10;
    #1 checkOutput("nonload_stalls", stall_vec(), 32'h0);
    hz.result_srcE = 2'b01; hz.rdE = 5'd0; hz.rs2D = 5'd0;
    #1 checkOutput("load_x0_stalls", stall_vec(), 32'h0);
    hz.result_srcE = 2'b00;

    applyStimulus(1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("br_stalls", stall_vec(), 32'h0);
    checkOutput("br_flush", flush_vec(), 32'h3);
    hz.result_srcE = 2'b01; hz.rdE = 5'd7; hz.rs1D = 5'd7;
    #1;
    checkOutput("br_lw_stalls", stall_vec(), 32'h0);
    checkOutput("br_lw_flush", flush_vec(), 32'h3);

    applyStimulus(1'b0, 1'b0, 1'b0);
    hz.result_srcE = 2'b00; hz.rdE = 5'd0; hz.rs1D = 5'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("mw1_stalls", stall_vec(), 32'hF);
    checkOutput("mw1_flush", flush_vec(), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      #2 checkOutput($sformatf("mw%0d_stalls", i), stall_vec(), 32'hF);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    #2;
    checkOutput("mw_ready_stalls", stall_vec(), 32'h0);
    checkOutput("mw_ready_cnt", 32'(hz.stall_cycles), 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("mw_done_stalls", stall_vec(), 32'h0);
    checkOutput("mw_done_cnt", 32'(hz.stall_cycles), 32'h4);

    hz.result_srcE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
    applyStimulus(1'b1, 1'b0, 1'b1);
    #2;
    checkOutput("all_mem_stalls", stall_vec(), 32'hF);
    checkOutput("all_mem_flush", flush_vec(), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    #2;
    checkOutput("all_rel_stalls", stall_vec(), 32'h0);
    checkOutput("all_rel_flush", flush_vec(), 32'h3);
    checkOutput("all_rel_cnt", 32'(hz.stall_cycles), 32'h5);
    hz.result_srcE = 2'b00; hz.rdE = 5'd0; hz.rs2D = 5'd0;

    applyStimulus(1'b1, 1'b1, 1'b0);
    #2 checkOutput("single_stalls", stall_vec(), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("single_next_stalls", stall_vec(), 32'h0);
    checkOutput("single_cnt", 32'(hz.stall_cycles), 32'h5);

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2 checkOutput("rmid_wait_stalls", stall_vec(), 32'hF);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2 checkOutput("rmid_cnt_before", 32'(hz.stall_cycles), 32'h7);
    reset = 1'b1;
    #1;
    checkOutput("rmid_stalls", stall_vec(), 32'h0);
    checkOutput("rmid_flush", flush_vec(), 32'h3);
    checkOutput("rmid_cnt", 32'(hz.stall_cycles), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    checkOutput("rmid_after_stalls", stall_vec(), 32'h0);
    checkOutput("rmid_after_flush", flush_vec(), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2 checkOutput("rmid_after_cnt", 32'(hz.stall_cycles), 32'h0);

`ifdef HAZ_MEM_TIMEOUT_EN
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2 checkOutput("to_enter_stalls", stall_vec(), 32'hF);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      #2 checkOutput($sformatf("to_wait%0d_stalls", k), stall_vec(), 32'hF);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("to_hit_stalls", stall_vec(), 32'h0);
    checkOutput("to_hit_flag", 32'(hz.mem_timeout), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("to_flag", 32'(hz.mem_timeout), 32'h1);
    checkOutput("to_run_stalls", stall_vec(), 32'h0);
    checkOutput("to_cnt", 32'(hz.stall_cycles), 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2 checkOutput("to_flag_sticky", 32'(hz.mem_timeout), 32'h1);
    reset = 1'b1;
    #1 checkOutput("to_flag_reset", 32'(hz.mem_timeout), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #2 checkOutput("to_flag_after", 32'(hz.mem_timeout), 32'h0);
`else
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (19) applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("long_wait_stalls", stall_vec(), 32'hF);
    checkOutput("sat_cnt", 32'(hz.stall_cycles), 32'hF);
    checkOutput("no_timeout", 32'(hz.mem_timeout), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #2 checkOutput("long_rel_stalls", stall_vec(), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("long_after_stalls", stall_vec(), 32'h0);
    checkOutput("sat_hold_cnt", 32'(hz.stall_cycles), 32'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
